// File: rtl/blast_pkg.sv
// Shared Blastn definitions: nucleotide codes, default field widths,
// the hit-entry record and a saturating counter helper.
package blast_pkg;

    typedef enum logic [1:0] {
        NT_A = 2'd0,
        NT_C = 2'd1,
        NT_G = 2'd2,
        NT_T = 2'd3
    } nucleotide_t;

    localparam int LENGTH_COUNTER_DEF = 8;
    localparam int LENGTH_ADDRESS_DEF = 16;
    localparam int CH_W_DEF           = 2;

    // Layout of one collected hit for the default widths; the collector packs
    // its FIFO words in this same field order {ch, Q, S, length}.
    typedef struct packed {
        logic [CH_W_DEF-1:0]           ch;
        logic [LENGTH_ADDRESS_DEF-1:0] addr_q;
        logic [LENGTH_COUNTER_DEF-1:0] addr_s;
        logic [LENGTH_COUNTER_DEF-1:0] length;
    } hit_entry_t;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous FIFO for collected hits. Head word is shown combinationally
// and forced to zero while empty so the outputs read zero after reset.
module hit_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array write.
    // NOTE: the data array has no reset; only pointers and count carry state
    // that matters, and stale words are never visible because dout is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/hit_collector.sv
// Merges hits from NUM_CH Blastn channels into one FIFO-buffered stream.
// Each channel has a one-deep pending register; a round-robin arbiter moves
// one pending hit per cycle into the FIFO. Optional min-length filter is
// enabled by defining HIT_COLLECTOR_MINLEN_FILTER_EN.
module hit_collector
    import blast_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int LENGTH_COUNTER = LENGTH_COUNTER_DEF,
    parameter int LENGTH         = 32,
    parameter int LENGTH_ADDRESS = LENGTH_ADDRESS_DEF,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                array_clk,
    input  logic                                reset,
    input  logic [NUM_CH-1:0]                   hit_valid,
    input  logic [NUM_CH*LENGTH_COUNTER-1:0]    hit_add_inQ,
    input  logic [NUM_CH*LENGTH_COUNTER-1:0]    hit_add_inS,
    input  logic [NUM_CH*LENGTH_COUNTER-1:0]    hit_length,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(NUM_CH)-1:0]           out_ch,
    output logic [LENGTH_ADDRESS-1:0]           out_addr_Q,
    output logic [LENGTH_COUNTER-1:0]           out_addr_S,
    output logic [LENGTH_COUNTER-1:0]           out_length,
    input  logic [LENGTH_COUNTER-1:0]           min_length,
    output logic [15:0]                         num_HSP_out,
    output logic [15:0]                         num_drop_out,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int LC      = LENGTH_COUNTER;
    localparam int LA      = LENGTH_ADDRESS;
    localparam int ENTRY_W = CH_W + LA + 2*LC;

    logic [NUM_CH-1:0] pend_valid;
    logic [LA-1:0]     pend_q   [NUM_CH];
    logic [LC-1:0]     pend_s   [NUM_CH];
    logic [LC-1:0]     pend_len [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;

    logic [NUM_CH-1:0] hit_ok;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic [15:0]       drop_cnt;
    logic              pop;
    logic              can_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign can_push  = !fifo_full || pop;

    // Qualify incoming strobes (optionally dropping short hits silently).
    always_comb begin
        hit_ok = hit_valid;
`ifdef HIT_COLLECTOR_MINLEN_FILTER_EN
        for (int c = 0; c < NUM_CH; c++) begin
            hit_ok[c] = hit_valid[c] && (hit_length[c*LC +: LC] >= min_length);
        end
`endif
    end

`ifndef HIT_COLLECTOR_MINLEN_FILTER_EN
    logic unused_min_length;
    assign unused_min_length = ^min_length;
`endif

    // Round-robin grant: first pending channel at or after rr_ptr.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!grant_any && pend_valid[idx] && can_push) begin
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    // Count hits that collide with an occupied, non-granted pending register.
    always_comb begin
        drop_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_ok[c] && pend_valid[c] && !grant[c]) begin
                drop_cnt = drop_cnt + 16'd1;
            end
        end
    end

    // Pending registers: capture when free or being drained this cycle.
    // NOTE: sequential state uses non-blocking assignment so all registers
    // update from the same pre-edge values.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            pend_valid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_q[c]   <= '0;
                pend_s[c]   <= '0;
                pend_len[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit_ok[c] && (!pend_valid[c] || grant[c])) begin
                    pend_valid[c] <= 1'b1;
                    pend_q[c]     <= LA'(hit_add_inQ[c*LC +: LC]) + LA'((NUM_CH-1-c)*LENGTH);
                    pend_s[c]     <= hit_add_inS[c*LC +: LC];
                    pend_len[c]   <= hit_length[c*LC +: LC];
                end else if (grant[c]) begin
                    pend_valid[c] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer and saturating statistics.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            num_HSP_out  <= '0;
            num_drop_out <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (int'(grant_idx) == NUM_CH-1) ? '0 : grant_idx + CH_W'(1);
            end
            num_HSP_out  <= sat_add16(num_HSP_out, {15'd0, grant_any});
            num_drop_out <= sat_add16(num_drop_out, drop_cnt);
        end
    end

    assign push_data = {grant_idx, pend_q[grant_idx], pend_s[grant_idx], pend_len[grant_idx]};

    hit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (array_clk),
        .rst   (reset),
        .push  (grant_any),
        .din   (push_data),
        .pop   (pop),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_ch     = head_data[ENTRY_W-1 -: CH_W];
    assign out_addr_Q = head_data[2*LC +: LA];
    assign out_addr_S = head_data[LC +: LC];
    assign out_length = head_data[0 +: LC];

endmodule

// File: tb/tb_hit_collector.sv
// Directed self-checking bench for hit_collector (default parameters).
module tb_hit_collector;

    logic        array_clk = 1'b0;
    logic        reset;
    logic [3:0]  hit_valid;
    logic [31:0] hit_add_inQ;
    logic [31:0] hit_add_inS;
    logic [31:0] hit_length;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [15:0] out_addr_Q;
    logic [7:0]  out_addr_S;
    logic [7:0]  out_length;
    logic [7:0]  min_length;
    logic [15:0] num_HSP_out;
    logic [15:0] num_drop_out;
    logic [4:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    hit_collector dut (
        .array_clk    (array_clk),
        .reset        (reset),
        .hit_valid    (hit_valid),
        .hit_add_inQ  (hit_add_inQ),
        .hit_add_inS  (hit_add_inS),
        .hit_length   (hit_length),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_addr_Q   (out_addr_Q),
        .out_addr_S   (out_addr_S),
        .out_length   (out_length),
        .min_length   (min_length),
        .num_HSP_out  (num_HSP_out),
        .num_drop_out (num_drop_out),
        .fifo_count   (fifo_count)
    );

    always #5 array_clk = ~array_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge array_clk);
        #1;
    endtask

    task automatic set_hit(input int c, input logic [7:0] q, input logic [7:0] s, input logic [7:0] len);
        hit_valid[c]           = 1'b1;
        hit_add_inQ[c*8 +: 8]  = q;
        hit_add_inS[c*8 +: 8]  = s;
        hit_length[c*8 +: 8]   = len;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        hit_valid = '0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] last_q;
        hit_add_inQ = '0;
        hit_add_inS = '0;
        hit_length  = '0;
        min_length  = 8'd0;
        do_reset();

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_hsp", num_HSP_out, 0);
        check("rst_drop", num_drop_out, 0);
        check("rst_addrq", out_addr_Q, 0);

        // Single hit on ch2: 2-edge latency, Q = 5 + 1*32
        set_hit(2, 8'd5, 8'd9, 8'd3);
        tick();
        hit_valid = '0;
        check("lat_edge1_valid", out_valid, 0);
        tick();
        check("single_valid", out_valid, 1);
        check("single_ch", out_ch, 2);
        check("single_q", out_addr_Q, 37);
        check("single_s", out_addr_S, 9);
        check("single_len", out_length, 3);
        check("single_hsp", num_HSP_out, 1);
        out_ready = 1'b1;
        tick();
        check("single_popped", out_valid, 0);

        // Round robin resumes after ch2: ch3 before ch1
        set_hit(1, 8'd0, 8'd1, 8'd1);
        set_hit(3, 8'd0, 8'd3, 8'd1);
        tick();
        hit_valid = '0;
        tick();
        check("rr_first_ch", out_ch, 3);
        tick();
        check("rr_second_ch", out_ch, 1);
        check("rr_second_q", out_addr_Q, 64);
        tick();

        // All four channels at once, drained in order ch0..ch3
        do_reset();
        for (int c = 0; c < 4; c++) set_hit(c, 8'(c + 1), 8'(c + 10), 8'(c + 20));
        out_ready = 1'b1;
        tick();
        hit_valid = '0;
        tick();
        for (int c = 0; c < 4; c++) begin
            check("all4_valid", out_valid, 1);
            check("all4_ch", out_ch, c);
            check("all4_q", out_addr_Q, (c + 1) + (3 - c) * 32);
            check("all4_s", out_addr_S, c + 10);
            tick();
        end
        check("all4_empty", out_valid, 0);
        check("all4_drop", num_drop_out, 0);
        check("all4_hsp", num_HSP_out, 4);

        // Backpressure: fill FIFO, stall one hit, drop the next
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_hit(0, 8'(i), 8'(i), 8'd5);
            tick();
        end
        hit_valid = '0;
        check("full_count", fifo_count, 16);
        check("full_hsp", num_HSP_out, 16);
        check("full_drop", num_drop_out, 1);
        check("full_head_q", out_addr_Q, 96);
        out_ready = 1'b1;
        n = 0;
        last_q = '0;
        while (out_valid && n < 40) begin
            last_q = out_addr_Q;
            n++;
            tick();
        end
        check("drain_entries", n, 17);
        check("drain_last_q", last_q, 112);
        check("drain_hsp", num_HSP_out, 17);

        // Min-length filter
        do_reset();
        min_length = 8'd4;
        out_ready  = 1'b1;
        set_hit(0, 8'd7, 8'd1, 8'd3);
        set_hit(1, 8'd8, 8'd2, 8'd4);
        tick();
        hit_valid = '0;
        tick();
`ifdef HIT_COLLECTOR_MINLEN_FILTER_EN
        check("filt_ch", out_ch, 1);
        check("filt_len", out_length, 4);
        tick();
        check("filt_empty", out_valid, 0);
        check("filt_hsp", num_HSP_out, 1);
        check("filt_drop", num_drop_out, 0);
`else
        check("nofilt_ch0", out_ch, 0);
        check("nofilt_len0", out_length, 3);
        tick();
        check("nofilt_ch1", out_ch, 1);
        check("nofilt_len1", out_length, 4);
        tick();
        check("nofilt_empty", out_valid, 0);
        check("nofilt_hsp", num_HSP_out, 2);
`endif
        min_length = 8'd0;

        // Asynchronous reset with 5 entries queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_hit(0, 8'(i), 8'd0, 8'd1);
            tick();
        end
        hit_valid = '0;
        tick();
        check("pre_rst_count", fifo_count, 5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", fifo_count, 0);
        check("arst_hsp", num_HSP_out, 0);
        check("arst_drop", num_drop_out, 0);
        check("arst_q", out_addr_Q, 0);
        tick();
        reset = 1'b0;
        set_hit(3, 8'd2, 8'd4, 8'd6);
        tick();
        hit_valid = '0;
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_ch", out_ch, 3);
        check("post_rst_q", out_addr_Q, 2);
        check("post_rst_count", fifo_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_collector.md
HIT_COLLECTOR -- requirements
Module: hit_collector

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of Blastn channels merged.
REQ-002 SHALL have parameter LENGTH_COUNTER, default 8: width of per-channel Q/S address and length fields.
REQ-003 SHALL have parameter LENGTH, default 32: query segment length per channel.
REQ-004 SHALL have parameter LENGTH_ADDRESS, default 16: width of the global query address.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16 (power of 2): output FIFO entries.
REQ-006 SHALL have ports: array_clk in 1, clock; reset in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: hit_valid in NUM_CH, per-channel hit strobe; hit_add_inQ in NUM_CH*LENGTH_COUNTER, local Q address; hit_add_inS in NUM_CH*LENGTH_COUNTER, S address; hit_length in NUM_CH*LENGTH_COUNTER, length-1 code.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_ch out clog2(NUM_CH); out_addr_Q out LENGTH_ADDRESS; out_addr_S out LENGTH_COUNTER; out_length out LENGTH_COUNTER.
REQ-009 SHALL have ports: min_length in LENGTH_COUNTER, filter threshold; num_HSP_out out 16, accepted-hit count; num_drop_out out 16, dropped-hit count; fifo_count out clog2(FIFO_DEPTH)+1, occupancy.

Function
REQ-010 SHALL hold one pending-hit register per channel; a channel captures a hit when hit_valid[c]=1 and its register is empty, or is being granted in the same cycle.
REQ-011 SHALL drop a hit arriving on a channel whose register is occupied and not granted that cycle, and increment num_drop_out.
REQ-012 SHALL compute out_addr_Q = hit_add_inQ + (NUM_CH-1-c)*LENGTH, zero-extended to LENGTH_ADDRESS and truncated modulo 2^LENGTH_ADDRESS.
REQ-013 SHALL grant at most one pending channel per cycle using round-robin, starting the search at the channel after the last grant; after reset the search starts at channel 0.
REQ-014 SHALL grant only when the FIFO is not full, or is full and popped in the same cycle.
REQ-015 SHALL write the granted entry {c, Q, S, length} into the FIFO in the grant cycle and clear that channel's register.
REQ-016 SHALL present the FIFO head on out_* with out_valid=1 while the FIFO is non-empty; pop occurs when out_valid and out_ready are both 1.
REQ-017 SHALL have a latency of 2 array_clk edges from hit_valid capture to out_valid, when there is no contention and the FIFO is empty.
REQ-018 SHALL support simultaneous push and pop when the FIFO is full or empty-with-pending, leaving fifo_count unchanged.
REQ-019 SHALL increment num_HSP_out once per FIFO write; both counters saturate at 16'hFFFF.
REQ-020 SHALL leave out_* data stable while out_valid=1 and out_ready=0.

Reset
REQ-021 SHALL, on reset=1, asynchronously clear all pending registers, the FIFO pointers, the round-robin pointer, num_HSP_out, num_drop_out and fifo_count, and drive out_valid=0 and out_* data=0.
REQ-022 SHALL discard in-flight hits on reset mid-operation; the first cycle after deassertion accepts new hits.

Configuration
REQ-023 SHALL, with HIT_COLLECTOR_MINLEN_FILTER_EN defined, silently discard hits whose hit_length < min_length before capture, counting them in neither counter.
REQ-024 SHALL, without HIT_COLLECTOR_MINLEN_FILTER_EN, ignore min_length and capture every hit.

Structure
REQ-025 SHALL place the nucleotide codes, LENGTH_COUNTER/LENGTH_ADDRESS defaults and the hit-entry record typedef in shared package blast_pkg.
REQ-026 SHALL implement the output FIFO as sub-module hit_fifo (parameters: width, depth; ports: push, pop, full, empty, count).

Verification
REQ-027 The bench SHALL check: single hit on ch2, Q=5, S=9, len=3 -> after 2 edges out_ch=2, out_addr_Q=37, out_addr_S=9, out_length=3, num_HSP_out=1.
REQ-028 The bench SHALL check: all 4 channels strobed in one cycle, out_ready=1 -> outputs in order ch0, ch1, ch2, ch3 on consecutive cycles, num_drop_out=0.
REQ-029 The bench SHALL check: out_ready=0, 17 or more hits applied -> fifo_count=16, further hits stall in the pending registers, and a second hit on a stalled channel gives num_drop_out=1.
REQ-030 The bench SHALL check: filter on, min_length=4, hits of len 3 and len 4 -> only the len-4 hit is output, num_HSP_out=1; with the filter off, both hits are output.
REQ-031 The bench SHALL check: reset pulse asserted with 5 entries queued -> out_valid=0 immediately, fifo_count=0, and both counters are 0.
